// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples SCLK/MOSI/CS_N on wr_clk and pushes MSB-first words into a FIFO.
// Optional build macro SPI_RX_STATUS_EN shifts a {wr_full, ovf, 0...} status word out on miso.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_en,
  input  logic                  wr_full,
  output logic                  ovf,
  input  logic                  ovf_clr,
  output logic                  frame_err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_fill;
  logic                   r_sclk_prev, r_cs_prev, r_armed;
  logic                   w_sclk, w_cs, w_mosi;
  logic                   w_scl_rise, w_cs_fall, w_cs_rise;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_bit_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic                   w_done, w_ferr;

  logic [DATA_WIDTH-1:0]  r_wr_data;
  logic                   r_wr_en, r_ovf, r_frame_err;

  // r_fill marks when the sync chain holds real pin samples rather than reset values;
  // only a CS_N seen high after that point arms the receiver.
  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_fill      <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b1;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs;
      r_armed     <= r_armed | (r_fill[SYNC_STAGES-1] & w_cs);
    end
  end

  assign w_sclk     = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs       = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_sclk & ~r_sclk_prev;
  assign w_cs_fall  = ~w_cs & r_cs_prev & r_armed;
  assign w_cs_rise  = w_cs & ~r_cs_prev;
  assign w_done     = w_scl_rise && (r_bit_cnt == CW'(DATA_WIDTH - 1));

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_ferr      = 1'b0;
    // Shifting stays enabled in PUSH so a back-to-back first bit is not lost.
    if (r_state != IDLE && w_scl_rise)
      w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_mosi};
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_cs_fall) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        if (w_done) begin
          w_state_nxt = PUSH;
          w_cnt_nxt   = '0;
        end else if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
          w_ferr      = (r_bit_cnt != '0) || w_scl_rise;
        end else if (w_scl_rise) begin
          w_cnt_nxt = r_bit_cnt + CW'(1);
        end
      end
      PUSH: begin
        if (w_cs) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = w_scl_rise ? CW'(1) : '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_en     <= (r_state == PUSH) && !wr_full;
      r_frame_err <= w_ferr;
      if (r_state == PUSH && !wr_full) r_wr_data <= r_shift;
      if (r_state == PUSH && wr_full) r_ovf <= 1'b1;
      else if (ovf_clr)               r_ovf <= 1'b0;
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign ovf       = r_ovf;
  assign frame_err = r_frame_err;

`ifdef SPI_RX_STATUS_EN
  logic [DATA_WIDTH-1:0] r_status;
  logic                  w_scl_fall;

  assign w_scl_fall = ~w_sclk & r_sclk_prev;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)
      r_status <= '0;
    else if (r_state == IDLE && w_cs_fall)
      r_status <= {wr_full, r_ovf, {(DATA_WIDTH-2){1'b0}}};
    else if (r_state == PUSH)
      r_status <= {wr_full, r_ovf | wr_full, {(DATA_WIDTH-2){1'b0}}};
    else if (r_state == SHIFT && w_scl_fall)
      r_status <= {r_status[DATA_WIDTH-2:0], 1'b0};
  end

  assign miso = (r_state != IDLE) & r_status[DATA_WIDTH-1];
`else
  assign miso = 1'b0;
`endif

endmodule
